// File: rtl/bcd_a_bin_pkg.sv
// Shared constants for the BCD<->binary paths: error convention,
// nibble width and the converter FSM encoding.
package bcd_a_bin_pkg;

    localparam int MAX_DECIMAL = 9999;
    localparam int ERR_VAL     = 9999;
    localparam int NIB_W       = 4;
    localparam int BIN_W       = 14;
    localparam int BCD_DIGITS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic nib_bad(input logic [NIB_W-1:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble correction: a BCD nibble >= 8 after a
// right shift is pulled back into decimal range by subtracting 3.
module bcd_nibble_corr
    import bcd_a_bin_pkg::*;
(
    input  logic [NIB_W-1:0] nib_in,
    output logic [NIB_W-1:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (nib_in >= 4'd8) begin
            nib_out = nib_in - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_a_bin.sv
// Iterative BCD-to-binary converter, one reverse double-dabble
// step per clock, framed by a START/BUSY/DONE handshake.
module bcd_a_bin
    import bcd_a_bin_pkg::*;
#(
    parameter int BITS      = BIN_W,
    parameter int DIGITS    = BCD_DIGITS,
    parameter int ERROR_VAL = ERR_VAL
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [NIB_W*DIGITS-1:0] BCD_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [BITS-1:0]       O,
    output logic                  ERROR
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int SR_W  = BCD_W + BITS;
    localparam logic [3:0] LAST_IT = 4'(BITS - 1);

    state_t            state, state_nx;
    logic [SR_W-1:0]   sr, sr_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              tag, tag_nx;
    logic [BITS-1:0]   o_nx;
    logic              err_nx, done_nx, busy_nx;
    logic              bad_in;
    logic [SR_W-1:0]   shifted;
    logic [BCD_W-1:0]  corr;
    logic [SR_W-1:0]   sr_step;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nib_bad(BCD_IN[i*NIB_W +: NIB_W])) begin
                bad_in = 1'b1;
            end
        end
    end

    assign shifted = {1'b0, sr[SR_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_corr u_corr (
            .nib_in  (shifted[BITS + g*NIB_W +: NIB_W]),
            .nib_out (corr[g*NIB_W +: NIB_W])
        );
    end

    assign sr_step = {corr, shifted[BITS-1:0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nx = bad_in ? ST_FINISH : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST_IT) begin
                    state_nx = ST_FINISH;
                end
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        sr_nx   = sr;
        cnt_nx  = cnt;
        tag_nx  = tag;
        o_nx    = O;
        err_nx  = ERROR;
        done_nx = 1'b0;
        busy_nx = BUSY;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    sr_nx   = {BCD_IN, {BITS{1'b0}}};
                    cnt_nx  = '0;
                    tag_nx  = bad_in;
                    busy_nx = !bad_in;
                end
            end
            ST_SHIFT: begin
                sr_nx  = sr_step;
                cnt_nx = cnt + 4'd1;
            end
            ST_FINISH: begin
                done_nx = 1'b1;
                busy_nx = 1'b0;
                tag_nx  = 1'b0;
                if (tag) begin
                    o_nx   = BITS'(ERROR_VAL);
                    err_nx = 1'b1;
                end else begin
                    o_nx   = sr[BITS-1:0];
                    err_nx = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr    <= '0;
            cnt   <= '0;
            tag   <= 1'b0;
            O     <= '0;
            ERROR <= 1'b0;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            tag   <= tag_nx;
            O     <= o_nx;
            ERROR <= err_nx;
            DONE  <= done_nx;
            BUSY  <= busy_nx;
        end
    end

endmodule

// File: tb/tb_bcd_a_bin.sv
// Directed bench for bcd_a_bin: latency, values, error path,
// handshake rules and asynchronous reset.
module tb_bcd_a_bin;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [15:0] BCD_IN;
    logic        BUSY;
    logic        DONE;
    logic [13:0] O;
    logic        ERROR;

    int errors = 0;
    int checks = 0;

    bcd_a_bin dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .BCD_IN (BCD_IN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .O      (O),
        .ERROR  (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse START for one edge, then count edges until DONE.
    task automatic convert(input string tag, input logic [15:0] bcd,
                           input int exp_o, input logic exp_err,
                           input int exp_lat);
        int  n;
        bit  busy_seen;
        bit  overlap;
        n = 0;
        busy_seen = 0;
        overlap = 0;
        START  = 1'b1;
        BCD_IN = bcd;
        tick();
        START = 1'b0;
        if (BUSY) busy_seen = 1;
        while (!DONE && n < 40) begin
            tick();
            n++;
            if (BUSY) busy_seen = 1;
            if (BUSY && DONE) overlap = 1;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_o"}, O, exp_o);
        chk({tag, "_err"}, ERROR, exp_err);
        chk({tag, "_busy_seen"}, busy_seen, !exp_err);
        chk({tag, "_overlap"}, overlap, 0);
        tick();
        chk({tag, "_done_pulse"}, DONE, 0);
    endtask

    initial begin
        int n;
        int dones;
        int first_done;
        int last_done;
        int gap_bad;
        int o_bad;
        bit overlap;

        RST_N  = 1'b0;
        START  = 1'b0;
        BCD_IN = '0;
        #12;
        chk("rst_o", O, 0);
        chk("rst_done", DONE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERROR, 0);
        tick();
        RST_N = 1'b1;
        tick();

        // Test 1
        START  = 1'b1;
        BCD_IN = 16'h1234;
        tick();
        START = 1'b0;
        tick();
        chk("t1_busy_n1", BUSY, 1);
        chk("t1_done_n1", DONE, 0);
        n = 1;
        while (!DONE && n < 40) begin
            tick();
            n++;
        end
        chk("t1_lat", n, 15);
        chk("t1_o", O, 1234);
        chk("t1_err", ERROR, 0);
        chk("t1_busy_at_done", BUSY, 0);
        tick();
        chk("t1_done_pulse", DONE, 0);
        chk("t1_o_hold", O, 1234);

        // Test 2
        convert("t2_9999", 16'h9999, 9999, 1'b0, 15);
        convert("t2_0000", 16'h0000, 0, 1'b0, 15);

        // Test 3
        convert("t3_12a4", 16'h12A4, 9999, 1'b1, 1);
        convert("t3_0042", 16'h0042, 42, 1'b0, 15);
        convert("t3_f000", 16'hF000, 9999, 1'b1, 1);
        convert("t3_8001", 16'h8001, 8001, 1'b0, 15);

        // Test 4: START during BUSY is ignored
        START  = 1'b1;
        BCD_IN = 16'h0500;
        tick();
        START = 1'b0;
        dones = 0;
        first_done = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i >= 3 && i <= 5) begin
                START  = 1'b1;
                BCD_IN = 16'h0001;
            end else begin
                START = 1'b0;
            end
            tick();
            if (DONE) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
        end
        chk("t4_lat", first_done, 15);
        chk("t4_dones", dones, 1);
        chk("t4_o_hold", O, 500);
        chk("t4_busy_idle", BUSY, 0);

        // Test 5: START held, back-to-back conversions
        START  = 1'b1;
        BCD_IN = 16'h0007;
        tick();
        dones = 0;
        first_done = -1;
        last_done = -1;
        gap_bad = 0;
        o_bad = 0;
        overlap = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (BUSY && DONE) overlap = 1;
            if (DONE) begin
                dones++;
                if (O !== 14'd7) o_bad++;
                if (last_done >= 0 && i - last_done != 16) gap_bad++;
                if (first_done < 0) first_done = i;
                last_done = i;
            end
        end
        START = 1'b0;
        chk("t5_first", first_done, 15);
        chk("t5_dones", dones, 3);
        chk("t5_gap", gap_bad, 0);
        chk("t5_o", o_bad, 0);
        chk("t5_overlap", overlap, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_idle", BUSY, 0);

        // Test 6: asynchronous reset mid-conversion
        START  = 1'b1;
        BCD_IN = 16'h8765;
        tick();
        START = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_rst_o", O, 0);
        chk("t6_rst_busy", BUSY, 0);
        chk("t6_rst_done", DONE, 0);
        chk("t6_rst_err", ERROR, 0);
        tick();
        RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (DONE || BUSY) dones++;
        end
        chk("t6_no_done", dones, 0);
        convert("t6_8765", 16'h8765, 8765, 1'b0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
